fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the async FIFO's write side among several producers in the `w_clk` domain. Each requester presents a valid/ready/data stream. The arbiter grants one requester at a time for a bounded burst and drives the FIFO `write_enable`/`write_data` pins. It honours the FIFO `full` flag and the register-mapped `flush` control bit.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write-side blocks.
//   arb_state_t : write-port arbiter FSM states
//   FIFO_DATA_W : default FIFO data width
//   CTRL_ADDR / STAT_ADDR : register map addresses
//   FLUSH_BIT / EMPTY_BIT : bit positions within CTRL / STAT registers
package fifo_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int unsigned FIFO_DATA_W = 8;

  localparam logic [7:0] CTRL_ADDR = 8'h00;
  localparam logic [7:0] STAT_ADDR = 8'h01;

  localparam int unsigned FLUSH_BIT = 0;
  localparam int unsigned EMPTY_BIT = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req_i upward from ptr_i+1 (wrapping) and returns the first set index.
//   req_i    : request vector
//   ptr_i    : last-served index
//   winner_o : index of the selected requester (0 when none)
//   found_o  : high when any request is set
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               found_o
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down to ptr+1 so the nearest match is written last.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = IDX_W'((int'(ptr_i) + k) % int'(NUM_REQ));
      if (req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// Grants one requester at a time for up to MAX_BURST beats; honours full and flush.
//   w_clk, w_rst         : write clock, synchronous active-high reset
//   req_valid/req_data   : per-requester stream in (lane i at [i*DATA_W +: DATA_W])
//   req_ready            : per-requester beat accepted (one-hot or zero)
//   full, flush          : FIFO full flag, control-register flush bit
//   write_enable/_data   : FIFO write strobe and data (data 0 when no beat)
//   grant_id, busy       : current/last grant, high while granting
//   beat_count           : per-requester 16-bit saturating beat counters, present only
//                          when FIFO_WR_ARB_STATS_EN is defined
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        w_clk,
  input  logic                        w_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        full,
  input  logic                        flush,
  output logic                        write_enable,
  output logic [DATA_W-1:0]           write_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       beat_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             beat;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_idx),
    .found_o  (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    beat        = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // full does not block arbitration; only flush does.
        if (pick_found && !flush) begin
          state_d     = ARB_GRANT;
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        beat = req_valid[grant_id_q] && !full && !flush;
        if (beat) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        // A full stall with valid held keeps the grant and the count.
        if (flush || !req_valid[grant_id_q] ||
            (beat && burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
          state_d     = ARB_IDLE;
          rr_ptr_d    = grant_id_q;
          burst_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    write_enable = beat;
    req_ready    = beat ? (NUM_REQ'(1) << grant_id_q) : '0;
    write_data   = beat ? data_arr[grant_id_q] : '0;
    grant_id     = grant_id_q;
    busy         = (state_q == ARB_GRANT);
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (req_ready[i] && cnt_q[i] != 16'hFFFF) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign beat_count[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
// Each cycle's expected {busy, write_enable, grant_id, req_ready, write_data} is hand-tabled.
// Producer lane i sends 0x10 + i*0x20 + (beats accepted so far on lane i).
module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        flush;
  logic        write_enable;
  logic [7:0]  write_data;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] beat_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sent [4];
  logic [15:0] obs;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .MAX_BURST (4)
  ) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .full         (full),
    .flush        (flush),
    .write_enable (write_enable),
    .write_data   (write_data),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_count   (beat_count)
`endif
  );

  assign obs = {busy, write_enable, grant_id, req_ready, write_data};

  // Expected observation vector; req_ready is one-hot on the granted lane only on a beat.
  function automatic logic [15:0] ev(input logic b, input logic we, input logic [1:0] g,
                                     input logic [7:0] d);
    logic [3:0] r;
    r = we ? (4'b0001 << g) : 4'b0000;
    return {b, we, g, r, (we ? d : 8'h00)};
  endfunction

  // Control word: {rst, flush, full, valid[3:0]}
  function automatic logic [6:0] ct(input logic r, input logic fl, input logic fu,
                                    input logic [3:0] v);
    return {r, fl, fu, v};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i * 32) + sent[i];
  endtask

  // Advance one clock: producers see their ready, inputs change at the falling edge.
  task automatic tick();
    for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) sent[i] = sent[i] + 8'd1;
    @(posedge w_clk);
    @(negedge w_clk);
    drive_data();
  endtask

  task automatic do_reset();
    w_rst = 1'b1; req_valid = '0; full = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) sent[i] = 8'h00;
    drive_data();
    tick();
    tick();
    w_rst = 1'b0;
  endtask

  task automatic apply(input logic [6:0] c);
    w_rst = c[6]; flush = c[5]; full = c[4]; req_valid = c[3:0];
  endtask

  task automatic test_reset();
    w_rst = 1'b1; req_valid = 4'b1111; full = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) sent[i] = 8'h00;
    drive_data();
    tick();
    #1;
    n_vec++;
    if (obs !== ev(0, 0, 0, 0)) begin
      n_err++; $display("FAIL reset_held: got %h want %h", obs, ev(0, 0, 0, 0));
    end
    w_rst = 1'b0; req_valid = 4'b0000;
    #1;
    n_vec++;
    if (obs !== ev(0, 0, 0, 0)) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", obs, ev(0, 0, 0, 0));
    end
    tick();
  endtask

  task automatic test_single_burst();
    logic [6:0]  cq [$];
    logic [15:0] eq [$];
    do_reset();
    cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(0, 0, 0, 8'h00));
    for (int k = 0; k < 4; k++) begin
      cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(1, 1, 0, 8'h10 + 8'(k)));
    end
    cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(0, 0, 0, 8'h00));
    for (int k = 0; k < 4; k++) begin
      cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(1, 1, 0, 8'h14 + 8'(k)));
    end
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(0, 0, 0, 8'h00));
    for (int c = 0; c < cq.size(); c++) begin
      apply(cq[c]);
      #1;
      n_vec++;
      if (obs !== eq[c]) begin
        n_err++; $display("FAIL single_burst cyc %0d: got %h want %h", c, obs, eq[c]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [6:0]  cq [$];
    logic [15:0] eq [$];
    logic [1:0]  g_tab [5];
    logic [7:0]  d_tab [5];
    g_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    d_tab = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h14};
    do_reset();
    cq.push_back(ct(0, 0, 0, 4'b1111)); eq.push_back(ev(0, 0, 0, 8'h00));
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 4; k++) begin
        cq.push_back(ct(0, 0, 0, 4'b1111)); eq.push_back(ev(1, 1, g_tab[n], d_tab[n] + 8'(k)));
      end
      cq.push_back(ct(0, 0, 0, (n == 4) ? 4'b0000 : 4'b1111));
      eq.push_back(ev(0, 0, g_tab[n], 8'h00));
    end
    for (int c = 0; c < cq.size(); c++) begin
      apply(cq[c]);
      #1;
      n_vec++;
      if (obs !== eq[c]) begin
        n_err++; $display("FAIL round_robin cyc %0d: got %h want %h", c, obs, eq[c]);
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    logic [6:0]  cq [$];
    logic [15:0] eq [$];
    do_reset();
    cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(0, 0, 0, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(1, 1, 0, 8'h10));
    cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(1, 1, 0, 8'h11));
    for (int k = 0; k < 10; k++) begin
      cq.push_back(ct(0, 0, 1, 4'b0001)); eq.push_back(ev(1, 0, 0, 8'h00));
    end
    cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(1, 1, 0, 8'h12));
    cq.push_back(ct(0, 0, 0, 4'b0001)); eq.push_back(ev(1, 1, 0, 8'h13));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(0, 0, 0, 8'h00));
    for (int c = 0; c < cq.size(); c++) begin
      apply(cq[c]);
      #1;
      n_vec++;
      if (obs !== eq[c]) begin
        n_err++; $display("FAIL full_stall cyc %0d: got %h want %h", c, obs, eq[c]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [6:0]  cq [$];
    logic [15:0] eq [$];
    do_reset();
    cq.push_back(ct(0, 0, 0, 4'b0010)); eq.push_back(ev(0, 0, 0, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b0010)); eq.push_back(ev(1, 1, 1, 8'h30));
    cq.push_back(ct(0, 1, 0, 4'b0010)); eq.push_back(ev(1, 0, 1, 8'h00));
    for (int k = 0; k < 3; k++) begin
      cq.push_back(ct(0, 1, 0, 4'b1111)); eq.push_back(ev(0, 0, 1, 8'h00));
    end
    cq.push_back(ct(0, 0, 0, 4'b1111)); eq.push_back(ev(0, 0, 1, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b1111)); eq.push_back(ev(1, 1, 2, 8'h50));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(1, 0, 2, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(0, 0, 2, 8'h00));
    for (int c = 0; c < cq.size(); c++) begin
      apply(cq[c]);
      #1;
      n_vec++;
      if (obs !== eq[c]) begin
        n_err++; $display("FAIL flush cyc %0d: got %h want %h", c, obs, eq[c]);
      end
      tick();
    end
  endtask

  task automatic test_valid_drop();
    logic [6:0]  cq [$];
    logic [15:0] eq [$];
    do_reset();
    cq.push_back(ct(0, 0, 0, 4'b1000)); eq.push_back(ev(0, 0, 0, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b1000)); eq.push_back(ev(1, 1, 3, 8'h70));
    cq.push_back(ct(0, 0, 0, 4'b1000)); eq.push_back(ev(1, 1, 3, 8'h71));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(1, 0, 3, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b1001)); eq.push_back(ev(0, 0, 3, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b1001)); eq.push_back(ev(1, 1, 0, 8'h10));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(1, 0, 0, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(0, 0, 0, 8'h00));
    for (int c = 0; c < cq.size(); c++) begin
      apply(cq[c]);
      #1;
      n_vec++;
      if (obs !== eq[c]) begin
        n_err++; $display("FAIL valid_drop cyc %0d: got %h want %h", c, obs, eq[c]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0]  cq [$];
    logic [15:0] eq [$];
    do_reset();
    cq.push_back(ct(0, 0, 0, 4'b0100)); eq.push_back(ev(0, 0, 0, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b0100)); eq.push_back(ev(1, 1, 2, 8'h50));
    cq.push_back(ct(1, 0, 0, 4'b0100)); eq.push_back(ev(1, 1, 2, 8'h51));
    cq.push_back(ct(0, 0, 0, 4'b0100)); eq.push_back(ev(0, 0, 0, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b0100)); eq.push_back(ev(1, 1, 2, 8'h52));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(1, 0, 2, 8'h00));
    cq.push_back(ct(0, 0, 0, 4'b0000)); eq.push_back(ev(0, 0, 2, 8'h00));
    for (int c = 0; c < cq.size(); c++) begin
      apply(cq[c]);
      #1;
      n_vec++;
      if (obs !== eq[c]) begin
        n_err++; $display("FAIL reset_mid cyc %0d: got %h want %h", c, obs, eq[c]);
      end
      tick();
    end
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    int beats;
    int cyc;
    do_reset();
    #1;
    n_vec++;
    if (beat_count !== 64'h0) begin
      n_err++; $display("FAIL stats_reset: got %h want %h", beat_count, 64'h0);
    end
    req_valid = 4'b0001;
    beats = 0;
    cyc = 0;
    while (beats < 100 && cyc < 400) begin
      #1;
      if (write_enable === 1'b1) beats++;
      if (beats == 100) req_valid = 4'b0000;
      tick();
      cyc++;
    end
    n_vec++;
    if (beats != 100) begin
      n_err++; $display("FAIL stats_budget: got %0d beats want %0d", beats, 100);
    end
    tick();
    #1;
    n_vec++;
    if (beat_count !== 64'h0000_0000_0000_0064) begin
      n_err++; $display("FAIL stats_count: got %h want %h", beat_count, 64'h64);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_vec++;
    if (beat_count !== 64'h0) begin
      n_err++; $display("FAIL stats_flush: got %h want %h", beat_count, 64'h0);
    end
    tick();
  endtask
`endif

  initial begin
    w_rst = 1'b1; req_valid = '0; full = 1'b0; flush = 1'b0; req_data = '0;
    @(negedge w_clk);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_flush();
    test_valid_drop();
    test_reset_mid();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
